// File: rtl/muldiv_sequencer_if.sv
// Handshake and result bundle between the execute stage and the iterative multiply/divide unit.
// The execute stage drives the master side, and the sequencer implements the slave side.
interface muldiv_sequencer_if #(
    parameter int WIDTH = 32
) ();
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             flush;
    logic             stall_req;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, src_a, src_b, flush,
        input  stall_req, busy, done, hi, lo
    );

    modport slave (
        input  start, op, src_a, src_b, flush,
        output stall_req, busy, done, hi, lo
    );
endinterface

// File: rtl/muldiv_sequencer.sv
// Radix-2 iterative MULT/MULTU/DIV/DIVU unit.
// It works on operand magnitudes, applies sign correction once at the end, and then writes HI/LO.
module muldiv_sequencer #(
    parameter int WIDTH = 32
) (
    input logic               clk,
    input logic               reset,
    muldiv_sequencer_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_e;

    localparam int              CW         = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]   COUNT_INIT = CW'(WIDTH);
    localparam logic [1:0]      OP_MULT    = 2'b00;
    localparam logic [1:0]      OP_DIV     = 2'b10;

    state_e           state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] accHi_q, accHi_d;
    logic [WIDTH-1:0] accLo_q, accLo_d;
    logic [WIDTH-1:0] operand_q, operand_d;
    logic [1:0]       op_q, op_d;
    logic             negA_q, negA_d;
    logic             negB_q, negB_d;
    logic             divZero_q, divZero_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;

    logic             signedOp;
    logic             negA, negB;
    logic [WIDTH-1:0] magA, magB;
    logic             divByZero;
    logic [WIDTH:0]   mulSum;
    logic [WIDTH:0]   divShift;
    logic [WIDTH-1:0] divRem;
    logic             noBorrow;
    logic [2*WIDTH-1:0] product;
    logic             signDiff;

    assign signedOp  = ~bus.op[0];
    assign negA      = signedOp & bus.src_a[WIDTH-1];
    assign negB      = signedOp & bus.src_b[WIDTH-1];
    assign magA      = negA ? -bus.src_a : bus.src_a;
    assign magB      = negB ? -bus.src_b : bus.src_b;
    assign divByZero = bus.op[1] & (bus.src_b == '0);

    // The running remainder is always below the divisor.
    // Because of that, the W-bit difference never wraps incorrectly once no borrow is seen.
    assign mulSum    = {1'b0, accHi_q} + {1'b0, operand_q};
    assign divShift  = {accHi_q, accLo_q[WIDTH-1]};
    assign noBorrow  = (divShift >= {1'b0, operand_q});
    assign divRem    = divShift[WIDTH-1:0] - operand_q;
    assign product   = {accHi_q, accLo_q};
    assign signDiff  = negA_q ^ negB_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            count_q   <= '0;
            accHi_q   <= '0;
            accLo_q   <= '0;
            operand_q <= '0;
            op_q      <= '0;
            negA_q    <= 1'b0;
            negB_q    <= 1'b0;
            divZero_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            accHi_q   <= accHi_d;
            accLo_q   <= accLo_d;
            operand_q <= operand_d;
            op_q      <= op_d;
            negA_q    <= negA_d;
            negB_q    <= negB_d;
            divZero_q <= divZero_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        accHi_d   = accHi_q;
        accLo_d   = accLo_q;
        operand_d = operand_q;
        op_d      = op_q;
        negA_d    = negA_q;
        negB_d    = negB_q;
        divZero_d = divZero_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start && !bus.flush) begin
                    op_d   = bus.op;
                    negA_d = negA;
                    negB_d = negB;
                    state_d = RUN;
                    // On a zero divisor, RUN is entered with count already exhausted.
                    // The dividend and all-ones quotient then pass straight through FIX.
                    if (divByZero) begin
                        divZero_d = 1'b1;
                        count_d   = '0;
                        accHi_d   = bus.src_a;
                        accLo_d   = '1;
                        operand_d = '0;
                    end else begin
                        divZero_d = 1'b0;
                        count_d   = COUNT_INIT;
                        accHi_d   = '0;
                        accLo_d   = bus.op[1] ? magA : magB;
                        operand_d = bus.op[1] ? magB : magA;
                    end
                end
            end
            RUN: begin
                if (bus.flush) begin
                    state_d = IDLE;
                end else if (count_q == '0) begin
                    state_d = FIX;
                end else begin
                    count_d = count_q - CW'(1);
                    if (op_q[1]) begin
                        accHi_d = noBorrow ? divRem : divShift[WIDTH-1:0];
                        accLo_d = {accLo_q[WIDTH-2:0], noBorrow};
                    end else if (accLo_q[0]) begin
                        accHi_d = mulSum[WIDTH:1];
                        accLo_d = {mulSum[0], accLo_q[WIDTH-1:1]};
                    end else begin
                        accHi_d = {1'b0, accHi_q[WIDTH-1:1]};
                        accLo_d = {accHi_q[0], accLo_q[WIDTH-1:1]};
                    end
                end
            end
            FIX: begin
                state_d = IDLE;
                if (!bus.flush) begin
                    done_d = 1'b1;
                    if (divZero_q) begin
                        hi_d = accHi_q;
                        lo_d = accLo_q;
                    end else if (!op_q[1]) begin
                        {hi_d, lo_d} = (op_q == OP_MULT && signDiff) ? -product : product;
                    end else begin
                        lo_d = (op_q == OP_DIV && signDiff) ? -accLo_q : accLo_q;
                        hi_d = (op_q == OP_DIV && negA_q)   ? -accHi_q : accHi_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    assign bus.stall_req = bus.start | (state_q != IDLE);
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.hi        = hi_q;
    assign bus.lo        = lo_q;
endmodule
